// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Types and constants shared by the SRAM access controller, its level
// converter and any behavioural SRAM model that talks to it.
//   ctrlState_t  : controller FSM states IDLE/SETUP/STROBE/WAIT/RESP
//   DEFAULT_VDD  : level driven for a logic 1 (volts)
//   DEFAULT_VTH  : threshold a sensed level must strictly exceed to read as 1
// ---------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT,
    RESP
  } ctrlState_t;

  localparam real DEFAULT_VDD = 1.8;
  localparam real DEFAULT_VTH = 0.9;

endpackage

// File: rtl/sram_level_conv.sv
// ---------------------------------------------------------------------------
// sram_level_conv
// Per-bit logic <-> analog level conversion for one SRAM bus.
//   i_bits   : logic bits to drive onto the bus
//   o_levels : driven levels, VDD for a 1 and 0.0 for a 0
//   i_levels : sensed levels coming back from the bus
//   o_bits   : sensed bits, 1 only when the level is strictly above VTH
// The drive and sense halves are independent, so a bus may loop its own
// drive back into the sense side without forming a combinational cycle.
// ---------------------------------------------------------------------------
module sram_level_conv
  import sram_pkg::*;
#(
  parameter int  WIDTH = 1,
  parameter real VDD   = DEFAULT_VDD,
  parameter real VTH   = DEFAULT_VTH
) (
  input  logic [WIDTH-1:0] i_bits,
  output real              o_levels [WIDTH],
  input  real              i_levels [WIDTH],
  output logic [WIDTH-1:0] o_bits
);

  // Drive side: a logic 1 becomes the full supply level, a 0 becomes ground.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      o_levels[i] = i_bits[i] ? VDD : 0.0;
    end
  end

  // Sense side: strict compare, so a level sitting exactly on the threshold
  // is treated as a 0 rather than an ambiguous 1.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      o_bits[i] = (i_levels[i] > VTH);
    end
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// ---------------------------------------------------------------------------
// sram_access_ctrl
// Turns single request/response transactions into an analog-level SRAM
// access sequence: SETUP (drive address/data/we), STROBE (one clock-high
// cycle), WAIT (RD_WAIT_CYCLES for the read delay), RESP (capture dout).
//   clk, rst        : system clock, synchronous active-high reset
//   req_valid/ready : request handshake, taken on an edge where both are high
//   req_we/addr/wdata : request contents, latched on acceptance
//   rsp_valid       : one-cycle response pulse
//   rsp_rdata       : word read (pre-write contents on a write), held
//   sram_clk/we     : SRAM strobe and write-enable levels
//   sram_addr/din   : SRAM address and write-data levels
//   sram_dout       : SRAM read-data levels
// ---------------------------------------------------------------------------
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int  DATA_WIDTH     = 8,
  parameter int  ADDR_WIDTH     = 4,
  parameter real VDD            = DEFAULT_VDD,
  parameter real VTH            = DEFAULT_VTH,
  parameter int  RD_WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output real                   sram_clk,
  output real                   sram_we,
  output real                   sram_addr [ADDR_WIDTH],
  output real                   sram_din  [DATA_WIDTH],
  input  real                   sram_dout [DATA_WIDTH]
);

  localparam int CNT_W = (RD_WAIT_CYCLES < 1) ? 1 : $clog2(RD_WAIT_CYCLES + 1);

  // A zero-cycle wait would sample dout in the same cycle as the strobe,
  // before the SRAM can possibly have answered, so refuse to build it.
  if (RD_WAIT_CYCLES < 1) begin : g_badWaitCycles
    $error("sram_access_ctrl: RD_WAIT_CYCLES must be at least 1");
  end

  ctrlState_t            r_state;
  ctrlState_t            w_nextState;
  logic                  r_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CNT_W-1:0]      r_count;
  logic                  r_rspValid;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_doutBits;
  real                   w_weLevel [1];
  logic [0:0]            w_unusedWeSense;
  logic [ADDR_WIDTH-1:0] w_unusedAddrSense;

  // Ready is a registered "we are back in IDLE" flag, masked by rst so a
  // request can never be taken on a reset edge and ready only rises on the
  // first edge after reset is released.
  assign req_ready = r_ready & ~rst;
  assign w_accept  = req_valid & req_ready;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rdata;
  assign sram_we   = w_weLevel[0];

  // Next-state and strobe decode. Only STROBE raises the SRAM clock, which
  // guarantees a single one-cycle pulse per transaction. WAIT leaves when the
  // counter loaded on the STROBE->WAIT edge is about to run out.
  always_comb begin
    w_nextState = r_state;
    sram_clk    = 0.0;
    unique case (r_state)
      IDLE:    if (w_accept) w_nextState = SETUP;
      SETUP:   w_nextState = STROBE;
      STROBE:  begin
                 w_nextState = WAIT;
                 sram_clk    = VDD;
               end
      WAIT:    if (r_count == CNT_W'(1)) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State, request latch, wait counter and response registers. The response
  // word and pulse are captured on the edge that leaves RESP, so rsp_rdata
  // then holds untouched until the next transaction reaches RESP. Reset
  // clears everything, which also drops every SRAM level to 0.0 and aborts
  // any in-flight transaction without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ready    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_count    <= '0;
      r_rspValid <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_nextState;
      r_ready    <= (w_nextState == IDLE);
      r_rspValid <= (r_state == RESP);
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == STROBE) begin
        r_count <= CNT_W'(RD_WAIT_CYCLES);
      end else if (r_state == WAIT) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (r_state == RESP) begin
        r_rdata <= w_doutBits;
      end
    end
  end

  // Write-enable bus. Its sense half reads back our own drive and has no
  // consumer today.
  sram_level_conv #(
    .WIDTH (1),
    .VDD   (VDD),
    .VTH   (VTH)
  ) u_weConv (
    .i_bits   (r_we),
    .o_levels (w_weLevel),
    .i_levels (w_weLevel),
    .o_bits   (w_unusedWeSense)
  );

  // Address bus, drive only in practice; readback sense is left unconsumed.
  sram_level_conv #(
    .WIDTH (ADDR_WIDTH),
    .VDD   (VDD),
    .VTH   (VTH)
  ) u_addrConv (
    .i_bits   (r_addr),
    .o_levels (sram_addr),
    .i_levels (sram_addr),
    .o_bits   (w_unusedAddrSense)
  );

  // Data bus: write data is driven out and read data is sensed back in.
  sram_level_conv #(
    .WIDTH (DATA_WIDTH),
    .VDD   (VDD),
    .VTH   (VTH)
  ) u_dataConv (
    .i_bits   (r_wdata),
    .o_levels (sram_din),
    .i_levels (sram_dout),
    .o_bits   (w_doutBits)
  );

endmodule

// File: tb/tb_sram_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_access_ctrl
// Drives sram_access_ctrl against a behavioural read-first SRAM that lives
// on the wreal pins, and predicts every response from a plain array holding
// what memory should contain.
// ---------------------------------------------------------------------------
module tb_sram_access_ctrl;

  localparam int  DW     = 8;
  localparam int  AW     = 4;
  localparam int  RDW    = 2;
  localparam int  DEPTH  = 1 << AW;
  localparam int  LAT    = 3 + RDW;
  localparam real VDD_TB = 1.8;
  localparam real VTH_TB = 0.9;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  real           sram_clk;
  real           sram_we;
  real           sram_addr [AW];
  real           sram_din  [DW];
  real           sram_dout [DW] = '{default: 0.0};

  int total = 0;
  int bad   = 0;
  int edgeCnt = 0;

  logic [DW-1:0] sramMem [DEPTH] = '{default: '0};
  logic [DW-1:0] refMem  [DEPTH] = '{default: '0};
  logic [DW-1:0] rspData [$];
  int            rspEdge [$];
  int strobeCount  = 0;
  int strobeRun    = 0;
  int maxStrobeRun = 0;
  int levelBad     = 0;

  sram_access_ctrl #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .VDD            (VDD_TB),
    .VTH            (VTH_TB),
    .RD_WAIT_CYCLES (RDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .sram_clk  (sram_clk),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Behavioural SRAM plus response monitor, evaluated mid-cycle. On the first
  // cycle of a strobe it decodes the pins, presents the old word on dout with
  // randomly chosen valid levels (including zeros exactly at threshold), then
  // commits a write. After each response dout is scrambled so a controller
  // that keeps sampling would be exposed.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      rspData.push_back(rsp_rdata);
      rspEdge.push_back(edgeCnt);
    end
    if (sram_clk != 0.0 && sram_clk != VDD_TB) levelBad++;
    if (sram_clk > VTH_TB) begin
      strobeRun++;
      if (strobeRun > maxStrobeRun) maxStrobeRun = strobeRun;
      if (strobeRun == 1) sramStrobe();
    end else begin
      strobeRun = 0;
    end
    if (rsp_valid === 1'b1) begin
      for (int i = 0; i < DW; i++) sram_dout[i] = ($urandom_range(0, 1) == 1) ? VDD_TB : 0.0;
    end
  end

  task automatic sramStrobe();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    logic [DW-1:0] old;
    strobeCount++;
    if (sram_we != 0.0 && sram_we != VDD_TB) levelBad++;
    w = (sram_we > VTH_TB);
    for (int i = 0; i < AW; i++) begin
      if (sram_addr[i] != 0.0 && sram_addr[i] != VDD_TB) levelBad++;
      a[i] = (sram_addr[i] > VTH_TB);
    end
    for (int i = 0; i < DW; i++) begin
      if (sram_din[i] != 0.0 && sram_din[i] != VDD_TB) levelBad++;
      d[i] = (sram_din[i] > VTH_TB);
    end
    old = sramMem[a];
    for (int i = 0; i < DW; i++) begin
      if (old[i]) begin
        sram_dout[i] = ($urandom_range(0, 1) == 1) ? VDD_TB : (VTH_TB + 0.1);
      end else begin
        case ($urandom_range(0, 2))
          0:       sram_dout[i] = 0.0;
          1:       sram_dout[i] = VTH_TB;
          default: sram_dout[i] = 0.45;
        endcase
      end
    end
    if (w) sramMem[a] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected response of one access: the word as it was, then the update.
  function automatic logic [DW-1:0] refAccess(input logic we, input logic [AW-1:0] a,
                                              input logic [DW-1:0] d);
    refAccess = refMem[a];
    if (we) refMem[a] = d;
  endfunction

  task automatic runTxn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat, output logic [DW-1:0] rd, output bit ok);
    int accEdge;
    int waitCnt;
    ok  = 1'b0;
    lat = -1;
    rd  = '0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    waitCnt = 0;
    while (req_ready !== 1'b1 && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    if (req_ready !== 1'b1) begin
      req_valid = 1'b0;
      return;
    end
    tick();
    accEdge   = edgeCnt;
    req_valid = 1'b0;
    waitCnt = 0;
    while (rspData.size() == 0 && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    if (rspData.size() == 0) return;
    rd  = rspData.pop_front();
    lat = rspEdge.pop_front() - accEdge;
    ok  = 1'b1;
  endtask

  task automatic test_reset();
    int nonZero;
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    tick(); tick(); tick();
    nonZero = 0;
    for (int i = 0; i < AW; i++) if (sram_addr[i] != 0.0) nonZero++;
    for (int i = 0; i < DW; i++) if (sram_din[i] != 0.0) nonZero++;
    if (sram_clk != 0.0) nonZero++;
    if (sram_we != 0.0) nonZero++;
    total++;
    if (nonZero != 0) begin bad++; $display("[TB] FAIL rst_levels: got %0d nonzero levels expected 0", nonZero); end
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready: got %b expected 0", req_ready); end
    total++;
    if (rsp_rdata !== '0) begin bad++; $display("[TB] FAIL rst_rdata: got %0h expected 0", rsp_rdata); end
    total++;
    if (strobeCount != 0) begin bad++; $display("[TB] FAIL rst_strobes: got %0d expected 0", strobeCount); end
    rst       = 1'b0;
    req_valid = 1'b0;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rel_ready_early: got %b expected 0", req_ready); end
    tick();
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rel_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_write_read();
    int lat;
    logic [DW-1:0] rd, exp;
    bit ok;
    exp = refAccess(1'b1, 4'h3, 8'hA5);
    runTxn(1'b1, 4'h3, 8'hA5, lat, rd, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL wr_done: got timeout expected response"); end
    total++;
    if (rd !== exp) begin bad++; $display("[TB] FAIL wr_old: got %0h expected %0h", rd, exp); end
    total++;
    if (lat != LAT) begin bad++; $display("[TB] FAIL wr_lat: got %0d expected %0d", lat, LAT); end
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL wr_pulse: got %b expected 0", rsp_valid); end
    exp = refAccess(1'b0, 4'h3, 8'h00);
    runTxn(1'b0, 4'h3, DW'($urandom), lat, rd, ok);
    total++;
    if (rd !== 8'hA5) begin bad++; $display("[TB] FAIL rd_data: got %0h expected a5", rd); end
    total++;
    if (lat != LAT) begin bad++; $display("[TB] FAIL rd_lat: got %0d expected %0d", lat, LAT); end
    tick(); tick();
    total++;
    if (rsp_rdata !== exp) begin bad++; $display("[TB] FAIL rd_hold: got %0h expected %0h", rsp_rdata, exp); end
  endtask

  task automatic test_read_first();
    int lat;
    logic [DW-1:0] rd, exp;
    bit ok;
    exp = refAccess(1'b1, 4'h7, 8'h3C);
    runTxn(1'b1, 4'h7, 8'h3C, lat, rd, ok);
    total++;
    if (rd !== exp) begin bad++; $display("[TB] FAIL rf_first: got %0h expected %0h", rd, exp); end
    exp = refAccess(1'b1, 4'h7, 8'hFF);
    runTxn(1'b1, 4'h7, 8'hFF, lat, rd, ok);
    total++;
    if (rd !== 8'h3C) begin bad++; $display("[TB] FAIL rf_second: got %0h expected 3c", rd); end
    exp = refAccess(1'b0, 4'h7, 8'h00);
    runTxn(1'b0, 4'h7, 8'h00, lat, rd, ok);
    total++;
    if (rd !== 8'hFF) begin bad++; $display("[TB] FAIL rf_read: got %0h expected ff", rd); end
  endtask

  task automatic test_back_to_back();
    logic          weArr  [3];
    logic [AW-1:0] aArr   [3];
    logic [DW-1:0] dArr   [3];
    logic [DW-1:0] expArr [3];
    int acc [$];
    int sc0;
    int idx;
    int waitCnt;
    for (int i = 0; i < 3; i++) begin
      weArr[i]  = ($urandom_range(0, 1) == 1);
      aArr[i]   = AW'($urandom);
      dArr[i]   = DW'($urandom);
      expArr[i] = refAccess(weArr[i], aArr[i], dArr[i]);
    end
    rspData.delete();
    rspEdge.delete();
    sc0 = strobeCount;
    maxStrobeRun = 0;
    idx = 0;
    req_valid = 1'b1;
    req_we    = weArr[0];
    req_addr  = aArr[0];
    req_wdata = dArr[0];
    for (int k = 0; k < 40 && idx < 3; k++) begin
      bit willAccept;
      willAccept = (req_ready === 1'b1);
      tick();
      if (willAccept) begin
        acc.push_back(edgeCnt);
        idx++;
        if (idx < 3) begin
          req_we    = weArr[idx];
          req_addr  = aArr[idx];
          req_wdata = dArr[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    waitCnt = 0;
    while (rspData.size() < 3 && waitCnt < 15) begin
      tick();
      waitCnt++;
    end
    total++;
    if (acc.size() != 3) begin bad++; $display("[TB] FAIL b2b_accepts: got %0d expected 3", acc.size()); end
    if (acc.size() == 3) begin
      total++;
      if (acc[1] - acc[0] != LAT + 1) begin bad++; $display("[TB] FAIL b2b_gap1: got %0d expected %0d", acc[1] - acc[0], LAT + 1); end
      total++;
      if (acc[2] - acc[1] != LAT + 1) begin bad++; $display("[TB] FAIL b2b_gap2: got %0d expected %0d", acc[2] - acc[1], LAT + 1); end
    end
    total++;
    if (strobeCount - sc0 != 3) begin bad++; $display("[TB] FAIL b2b_strobes: got %0d expected 3", strobeCount - sc0); end
    total++;
    if (maxStrobeRun != 1) begin bad++; $display("[TB] FAIL b2b_strobe_width: got %0d expected 1", maxStrobeRun); end
    total++;
    if (rspData.size() != 3) begin bad++; $display("[TB] FAIL b2b_rsps: got %0d expected 3", rspData.size()); end
    if (rspData.size() == 3 && acc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (rspData[i] !== expArr[i]) begin bad++; $display("[TB] FAIL b2b_data%0d: got %0h expected %0h", i, rspData[i], expArr[i]); end
        total++;
        if (rspEdge[i] - acc[i] != LAT) begin bad++; $display("[TB] FAIL b2b_lat%0d: got %0d expected %0d", i, rspEdge[i] - acc[i], LAT); end
      end
    end
    rspData.delete();
    rspEdge.delete();
  endtask

  task automatic test_reset_mid_wait();
    logic [AW-1:0] a;
    logic [DW-1:0] rd, exp;
    int lat;
    int waitCnt;
    bit ok;
    a = AW'($urandom);
    rspData.delete();
    rspEdge.delete();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    req_wdata = DW'($urandom);
    waitCnt = 0;
    while (req_ready !== 1'b1 && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    tick();
    req_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    total++;
    if (sram_clk != 0.0) begin bad++; $display("[TB] FAIL abort_clk: got %f expected 0.0", sram_clk); end
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_rsp_valid: got %b expected 0", rsp_valid); end
    total++;
    if (rsp_rdata !== '0) begin bad++; $display("[TB] FAIL abort_rdata: got %0h expected 0", rsp_rdata); end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    total++;
    if (rspData.size() != 0) begin bad++; $display("[TB] FAIL abort_no_rsp: got %0d responses expected 0", rspData.size()); end
    exp = refAccess(1'b0, a, 8'h00);
    runTxn(1'b0, a, 8'h00, lat, rd, ok);
    total++;
    if (!ok || rd !== exp) begin bad++; $display("[TB] FAIL abort_next_read: got %0h ok=%0d expected %0h", rd, ok, exp); end
  endtask

  task automatic test_sweep();
    int lat;
    logic [DW-1:0] rd, exp, d;
    bit ok;
    levelBad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      d   = DW'(a) ^ DW'(8'h5A);
      exp = refAccess(1'b1, AW'(a), d);
      runTxn(1'b1, AW'(a), d, lat, rd, ok);
      total++;
      if (!ok || rd !== exp) begin bad++; $display("[TB] FAIL sweep_wr%0d: got %0h expected %0h", a, rd, exp); end
    end
    for (int a = 0; a < DEPTH; a++) begin
      exp = refAccess(1'b0, AW'(a), 8'h00);
      runTxn(1'b0, AW'(a), DW'($urandom), lat, rd, ok);
      total++;
      if (!ok || rd !== (DW'(a) ^ DW'(8'h5A))) begin bad++; $display("[TB] FAIL sweep_rd%0d: got %0h expected %0h", a, rd, exp); end
    end
    total++;
    if (levelBad != 0) begin bad++; $display("[TB] FAIL sweep_levels: got %0d illegal levels expected 0", levelBad); end
  endtask

  task automatic test_random();
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd, exp;
    int lat;
    bit ok;
    for (int n = 0; n < 20; n++) begin
      we  = ($urandom_range(0, 1) == 1);
      a   = AW'($urandom);
      d   = DW'($urandom);
      exp = refAccess(we, a, d);
      runTxn(we, a, d, lat, rd, ok);
      total++;
      if (!ok || rd !== exp) begin bad++; $display("[TB] FAIL rand%0d_data: got %0h expected %0h", n, rd, exp); end
      total++;
      if (lat != LAT) begin bad++; $display("[TB] FAIL rand%0d_lat: got %0d expected %0d", n, lat, LAT); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_write_read();
    test_read_first();
    test_back_to_back();
    test_reset_mid_wait();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, data bits; ADDR_WIDTH, default 4, address bits; VDD, default 1.8, driven high level (real); VTH, default 0.9, logic threshold (real); RD_WAIT_CYCLES, default 2, wait cycles between SRAM strobe and dout sample.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports, in order, SHALL be:
- clk  in  1  system clock (logic).
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data (old contents on a write).
- sram_clk  out  wreal  SRAM clock level.
- sram_we  out  wreal  SRAM write-enable level.
- sram_addr  out  wreal[ADDR_WIDTH]  SRAM address levels.
- sram_din  out  wreal[DATA_WIDTH]  SRAM write-data levels.
- sram_dout  in  wreal[DATA_WIDTH]  SRAM read-data levels.

Function
REQ-004 The FSM SHALL have states IDLE, SETUP, STROBE, WAIT, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE with rst low; a request is accepted on a clk edge where req_valid && req_ready.
REQ-006 On acceptance, req_we/addr/wdata SHALL be latched; IDLE->SETUP.
REQ-007 SETUP: sram_we/addr/din SHALL drive the latched values (1->VDD, 0->0.0), sram_clk=0.0; ->STROBE after one cycle.
REQ-008 STROBE: sram_clk=VDD for exactly one cycle, other SRAM drives held; ->WAIT.
REQ-009 WAIT: sram_clk=0.0, drives held, down-counter loaded with RD_WAIT_CYCLES; ->RESP when the count expires after RD_WAIT_CYCLES cycles.
REQ-010 RESP: each rsp_rdata[i] SHALL register (sram_dout[i] > VTH); rsp_valid=1 for one cycle; ->IDLE.
REQ-011 Latency: a request accepted at edge N SHALL give rsp_valid high in cycle N+3+RD_WAIT_CYCLES (N+5 at default); throughput is one transaction per 4+RD_WAIT_CYCLES cycles.
REQ-012 A write SHALL return the pre-write word on rsp_rdata (read-first SRAM).
REQ-013 There is no response backpressure; rsp_valid SHALL be ignored-safe, and rsp_rdata SHALL hold its value until the next RESP.
REQ-014 sram_dout levels exactly equal to VTH SHALL read as 0.
REQ-015 req_valid held high in a non-IDLE state SHALL be ignored, with no queuing; the next request is taken on return to IDLE.
REQ-016 RD_WAIT_CYCLES x clk period SHALL exceed the SRAM read delay; RD_WAIT_CYCLES < 1 SHALL be a elaboration error.
REQ-017 Addresses SHALL have no wrap or range check; all 2^ADDR_WIDTH values are valid.

Reset
REQ-018 While rst is high at a clk edge: state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, latched request=0, counter=0, and all wreal outputs=0.0.
REQ-019 Reset in any state SHALL abort the transaction with no rsp_valid; a write already strobed is not undone.
REQ-020 req_ready SHALL rise on the first edge after rst falls.

Structure
REQ-021 Package sram_pkg SHALL hold the FSM state enum and default VDD/VTH constants shared with the SRAM model.
REQ-022 A sub-module sram_level_conv SHALL implement the per-bit logic<->real conversion (VDD/0.0 drive, > VTH compare) and is instantiated per bus.

Verification
REQ-023 Reset: rst high 3 cycles -> all wreal outputs 0.0, rsp_valid=0, req_ready=0; req_ready=1 one cycle after release.
REQ-024 Write then read: write addr 0x3 data 0xA5, then read addr 0x3 -> second rsp_rdata=0xA5, each rsp_valid at N+5.
REQ-025 Read-first write: write 0x3C to addr 0x7, then write 0xFF to addr 0x7 -> second response returns 0x3C; a following read returns 0xFF.
REQ-026 Back-to-back: req_valid held high for 3 requests -> exactly 3 acceptances, 6 cycles apart, strobes exactly one cycle at VDD.
REQ-027 Reset mid-WAIT of a read -> no rsp_valid, sram_clk 0.0 next edge, next read succeeds.
REQ-028 Sweep all 16 addresses with write of addr^0x5A, then read all -> every readback matches; sram_addr levels are only 0.0 or 1.8.
